// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, load-use/branch
// stalls, and a RUN/WAIT FSM that holds the pipeline while a multi-cycle memory access sits in M.
module pipe_hazard_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CW      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] RtDE,
  input  logic [4:0] RtDM,
  input  logic [4:0] RtDW,
  input  logic       RFWEE,
  input  logic       RFWEM,
  input  logic       RFWEW,
  input  logic       MtoRFSelE,
  input  logic       MtoRFSelM,
  input  logic       MemAccM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       BubbleW,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemBusy
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [CW-1:0] CNT_INIT = (MEM_LAT > 1) ? CW'(MEM_LAT - 2) : '0;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          memstall, lwstall, brstall, hz;

  // Register $0 is hard-wired, so a zero source never depends on an older instruction.
  function automatic logic match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    memstall  = 1'b0;
    case (state)
      S_RUN: begin
        if (MemAccM && (MEM_LAT > 1)) begin
          memstall  = 1'b1;
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          memstall = 1'b1;
          cnt_nxt  = cnt - CW'(1);
        end else begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
    if (RST) memstall = 1'b0;
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (match(RsE, RtDM) && RFWEM)      ForwardAE = 2'b10;
    else if (match(RsE, RtDW) && RFWEW) ForwardAE = 2'b01;
    if (match(RtE, RtDM) && RFWEM)      ForwardBE = 2'b10;
    else if (match(RtE, RtDW) && RFWEW) ForwardBE = 2'b01;
    ForwardAD = match(RsD, RtDM) && RFWEM;
    ForwardBD = match(RtD, RtDM) && RFWEM;
  end

  assign lwstall = MtoRFSelE && RFWEE && (match(RsD, RtDE) || match(RtD, RtDE));
  assign brstall = BranchD &&
                   ((RFWEE && (match(RsD, RtDE) || match(RtD, RtDE))) ||
                    (MtoRFSelM && (match(RsD, RtDM) || match(RtD, RtDM))));
  assign hz      = lwstall || brstall;
  assign MemBusy = (state == S_WAIT);

  // A memory wait freezes every stage, so it overrides the bubble insertion of lw/branch stalls.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    BubbleW = 1'b0;
    if (!RST) begin
      if (memstall) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        StallM  = 1'b1;
        BubbleW = 1'b1;
      end else begin
        StallF = hz;
        StallD = hz;
        FlushE = hz;
        FlushD = PCSrcD && !hz;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_LAT = 3, 4 and 1 instances sharing stimulus.
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] RsD, RtD, RsE, RtE, RtDE, RtDM, RtDW;
  logic       RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, MemAccM, BranchD, PCSrcD;

  logic       sf3, sd3, se3, sm3, fd3, fe3, bw3, mb3, fad3, fbd3;
  logic [1:0] fae3, fbe3;
  logic       sf4, sd4, se4, sm4, fd4, fe4, bw4, mb4, fad4, fbd4;
  logic [1:0] fae4, fbe4;
  logic       sf1, sd1, se1, sm1, fd1, fe1, bw1, mb1, fad1, fbd1;
  logic [1:0] fae1, fbe1;

  // Packed control view: StallF StallD StallE StallM FlushD FlushE BubbleW MemBusy
  logic [7:0] ctl3, ctl4, ctl1;
  assign ctl3 = {sf3, sd3, se3, sm3, fd3, fe3, bw3, mb3};
  assign ctl4 = {sf4, sd4, se4, sm4, fd4, fe4, bw4, mb4};
  assign ctl1 = {sf1, sd1, se1, sm1, fd1, fe1, bw1, mb1};

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.MEM_LAT(3), .CW(4)) dut3 (
    .CLK(CLK), .RST(RST), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .RtDE(RtDE), .RtDM(RtDM), .RtDW(RtDW), .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
    .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM), .MemAccM(MemAccM), .BranchD(BranchD),
    .PCSrcD(PCSrcD), .StallF(sf3), .StallD(sd3), .StallE(se3), .StallM(sm3),
    .FlushD(fd3), .FlushE(fe3), .BubbleW(bw3), .ForwardAD(fad3), .ForwardBD(fbd3),
    .ForwardAE(fae3), .ForwardBE(fbe3), .MemBusy(mb3));

  pipe_hazard_ctrl #(.MEM_LAT(4), .CW(4)) dut4 (
    .CLK(CLK), .RST(RST), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .RtDE(RtDE), .RtDM(RtDM), .RtDW(RtDW), .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
    .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM), .MemAccM(MemAccM), .BranchD(BranchD),
    .PCSrcD(PCSrcD), .StallF(sf4), .StallD(sd4), .StallE(se4), .StallM(sm4),
    .FlushD(fd4), .FlushE(fe4), .BubbleW(bw4), .ForwardAD(fad4), .ForwardBD(fbd4),
    .ForwardAE(fae4), .ForwardBE(fbe4), .MemBusy(mb4));

  pipe_hazard_ctrl #(.MEM_LAT(1), .CW(4)) dut1 (
    .CLK(CLK), .RST(RST), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .RtDE(RtDE), .RtDM(RtDM), .RtDW(RtDW), .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
    .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM), .MemAccM(MemAccM), .BranchD(BranchD),
    .PCSrcD(PCSrcD), .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1),
    .FlushD(fd1), .FlushE(fe1), .BubbleW(bw1), .ForwardAD(fad1), .ForwardBD(fbd1),
    .ForwardAE(fae1), .ForwardBE(fbe1), .MemBusy(mb1));

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; RtDE = 0; RtDM = 0; RtDW = 0;
    RFWEE = 0; RFWEM = 0; RFWEW = 0; MtoRFSelE = 0; MtoRFSelM = 0;
    MemAccM = 0; BranchD = 0; PCSrcD = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    MemAccM = 1; MtoRFSelE = 1; RFWEE = 1; RtDE = 8; RtD = 8;
    RsE = 5; RtDM = 5; RFWEM = 1;
    #1;
    checks++;
    if (ctl3 !== 8'b0) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl3, 8'b0); end
    checks++;
    if (fae3 !== 2'b10) begin errors++; $display("FAIL reset_fwd got %b exp %b", fae3, 2'b10); end
    clear_inputs();
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RsE = 5; RtDM = 5; RFWEM = 1; RtDW = 5; RFWEW = 1;
    #1;
    checks++;
    if (fae3 !== 2'b10) begin errors++; $display("FAIL fwd_ae_m got %b exp %b", fae3, 2'b10); end
    RFWEM = 0;
    #1;
    checks++;
    if (fae3 !== 2'b01) begin errors++; $display("FAIL fwd_ae_w got %b exp %b", fae3, 2'b01); end
    RsE = 0; RtDW = 0; RFWEM = 1; RtDM = 0;
    #1;
    checks++;
    if (fae3 !== 2'b00) begin errors++; $display("FAIL fwd_ae_r0 got %b exp %b", fae3, 2'b00); end
    RtE = 7; RtDW = 7; RFWEW = 1; RtDM = 3; RFWEM = 1;
    #1;
    checks++;
    if (fbe3 !== 2'b01) begin errors++; $display("FAIL fwd_be_w got %b exp %b", fbe3, 2'b01); end
    RsD = 3; RtD = 7;
    #1;
    checks++;
    if ({fad3, fbd3} !== 2'b10) begin errors++; $display("FAIL fwd_d got %b exp %b", {fad3, fbd3}, 2'b10); end
    RsD = 0; RtDM = 0;
    #1;
    checks++;
    if ({fad3, fbd3} !== 2'b00) begin errors++; $display("FAIL fwd_d_r0 got %b exp %b", {fad3, fbd3}, 2'b00); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    MtoRFSelE = 1; RFWEE = 1; RtDE = 8; RtD = 8; PCSrcD = 0;
    #1;
    checks++;
    if (ctl3 !== 8'b1100_0100) begin errors++; $display("FAIL lw_stall got %b exp %b", ctl3, 8'b1100_0100); end
    tick();
    MtoRFSelE = 0; RFWEE = 0; RtDE = 0; MtoRFSelM = 1; RFWEM = 1; RtDM = 8;
    #1;
    checks++;
    if (ctl3 !== 8'b0) begin errors++; $display("FAIL lw_release got %b exp %b", ctl3, 8'b0); end
    checks++;
    if (fbd3 !== 1'b1) begin errors++; $display("FAIL lw_fwd_bd got %b exp %b", fbd3, 1'b1); end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchD = 1; RsD = 9; RFWEE = 1; RtDE = 9; PCSrcD = 1;
    #1;
    checks++;
    if (ctl3 !== 8'b1100_0100) begin errors++; $display("FAIL br_stall_e got %b exp %b", ctl3, 8'b1100_0100); end
    tick();
    RFWEE = 0; RtDE = 0; RtDM = 9; RFWEM = 1;
    #1;
    checks++;
    if (ctl3 !== 8'b0000_1000) begin errors++; $display("FAIL br_taken got %b exp %b", ctl3, 8'b0000_1000); end
    checks++;
    if (fad3 !== 1'b1) begin errors++; $display("FAIL br_fwd_ad got %b exp %b", fad3, 1'b1); end
    MtoRFSelM = 1;
    #1;
    checks++;
    if (ctl3 !== 8'b1100_0100) begin errors++; $display("FAIL br_stall_m got %b exp %b", ctl3, 8'b1100_0100); end
    clear_inputs();
    tick();
  endtask

  task automatic test_mem_wait();
    logic [7:0] exp_seq [7];
    logic       acc_seq [7];
    exp_seq = '{8'b1111_0010, 8'b1111_0011, 8'b0000_0001,
                8'b1111_0010, 8'b1111_0011, 8'b0000_0001, 8'b0000_0000};
    acc_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    clear_inputs();
    for (int i = 0; i < 7; i++) begin
      MemAccM = acc_seq[i];
      #1;
      checks++;
      if (ctl3 !== exp_seq[i]) begin
        errors++;
        $display("FAIL mem_wait_c%0d got %b exp %b", i, ctl3, exp_seq[i]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'b1111_0010, 8'b1111_0011, 8'b1100_0101, 8'b0000_0000};
    clear_inputs();
    MtoRFSelE = 1; RFWEE = 1; RtDE = 8; RsD = 8;
    for (int i = 0; i < 4; i++) begin
      MemAccM = (i == 0);
      if (i == 3) begin MtoRFSelE = 0; RFWEE = 0; end
      #1;
      checks++;
      if (ctl3 !== exp_seq[i]) begin
        errors++;
        $display("FAIL prio_c%0d got %b exp %b", i, ctl3, exp_seq[i]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_midwait();
    clear_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    MemAccM = 1;
    #1;
    checks++;
    if (ctl4 !== 8'b1111_0010) begin errors++; $display("FAIL rstw_c0 got %b exp %b", ctl4, 8'b1111_0010); end
    tick();
    MemAccM = 0;
    #1;
    checks++;
    if (ctl4 !== 8'b1111_0011) begin errors++; $display("FAIL rstw_c1 got %b exp %b", ctl4, 8'b1111_0011); end
    RST = 1'b1;
    #1;
    checks++;
    if (ctl4 !== 8'b0000_0001) begin errors++; $display("FAIL rstw_held got %b exp %b", ctl4, 8'b0000_0001); end
    tick();
    RST = 1'b0;
    #1;
    checks++;
    if (ctl4 !== 8'b0) begin errors++; $display("FAIL rstw_after got %b exp %b", ctl4, 8'b0); end
    tick();
    checks++;
    if (ctl4 !== 8'b0) begin errors++; $display("FAIL rstw_abandon got %b exp %b", ctl4, 8'b0); end
  endtask

  task automatic test_mem_lat1();
    clear_inputs();
    MemAccM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl1 !== 8'b0) begin errors++; $display("FAIL lat1_c%0d got %b exp %b", i, ctl1, 8'b0); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_priority();
    test_reset_midwait();
    test_mem_lat1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined MIPS core (F/D/E/M/W).
- Drives stall/flush enables for the pipeline registers and forwarding selects for the D- and E-stage operand muxes.
- Inserts wait states while a multi-cycle data-memory access sits in the M stage.
- Resolves load-use, branch-compare and data-memory-latency hazards without software NOPs.

Parameters:
- MEM_LAT, 3, data-memory access latency in cycles (>=1); an access holds M for MEM_LAT-1 extra cycles.
- CW, 4, wait-counter width; must satisfy 2^CW > MEM_LAT.

Ports:
- CLK  in  1  pipeline clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- RsD, RtD  in  5  source register numbers in D.
- RsE, RtE  in  5  source register numbers in E.
- RtDE, RtDM, RtDW  in  5  destination register numbers in E/M/W.
- RFWEE, RFWEM, RFWEW  in  1  register-file write enables in E/M/W.
- MtoRFSelE, MtoRFSelM  in  1  load (memory-to-RF) select in E/M.
- MemAccM  in  1  load or store currently in M.
- BranchD  in  1  branch instruction in D.
- PCSrcD  in  1  branch taken, resolved in D.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE  out  1  clear the D/E pipeline register (bubble).
- BubbleW  out  1  force RFWEW low at the W register input.
- ForwardAD, ForwardBD  out  1  D-stage compare operand from ALU_outM.
- ForwardAE, ForwardBE  out  2  E-stage ALU operand select: 00 = RF, 01 = W result, 10 = ALU_outM.
- MemBusy  out  1  high while the FSM is in WAIT.

Behaviour:
- Register $0 never matches: any comparison where the source register is 0 is false.
- Forwarding (combinational):
  - ForwardAE = 10 if RsE==RtDM && RFWEM.
  - Else ForwardAE = 01 if RsE==RtDW && RFWEW.
  - Else ForwardAE = 00.
  - ForwardBE is the same using RtE.
  - ForwardAD = RsD==RtDM && RFWEM; ForwardBD uses RtD.
  - M takes priority over W.
- lwstall = MtoRFSelE && RFWEE && (RtDE==RsD || RtDE==RtD).
- brstall = BranchD && ((RFWEE && RtDE matches RsD/RtD) || (MtoRFSelM && RtDM matches RsD/RtD)).
- memstall, determined by the FSM:
  - States RUN and WAIT; CW-bit counter cnt.
  - RUN, MemAccM=1, MEM_LAT>1: memstall=1; next state WAIT, cnt<=MEM_LAT-2.
  - WAIT, cnt!=0: memstall=1, cnt<=cnt-1.
  - WAIT, cnt==0: memstall=0; next state RUN; the M instruction advances this cycle.
  - Total inserted cycles per access = MEM_LAT-1.
  - MEM_LAT==1: the FSM never leaves RUN and memstall is always 0.
  - A back-to-back access entering M in the cycle after WAIT->RUN starts a new wait normally.
- Output equations, with memstall having highest priority:
  - memstall=1: StallF=StallD=StallE=StallM=1; FlushD=FlushE=0; BubbleW=1.
  - Else: StallF=StallD=lwstall|brstall; FlushE=lwstall|brstall; StallE=StallM=0; BubbleW=0.
  - Else: FlushD = PCSrcD && !(lwstall|brstall).
- Forwarding outputs are computed from the inputs every cycle, regardless of stall.
- MemBusy = (state==WAIT).
- Reset:
  - RST=1 at a posedge sets state=RUN and cnt=0, including mid-WAIT; the pending wait is abandoned.
  - While RST is high, memstall=0 and all stall/flush/bubble outputs are 0.
  - Forwarding outputs still follow the inputs while RST is high.
- No other state is held; all non-FSM outputs are combinational from the inputs and the FSM state.

Test Plan:
- Forwarding: RsE=5, RtDM=5, RFWEM=1, RtDW=5, RFWEW=1 -> ForwardAE=10. Then RFWEM=0 -> ForwardAE=01. Then RsE=0 -> ForwardAE=00.
- Load-use: MtoRFSelE=1, RFWEE=1, RtDE=8, RtD=8 -> StallF=StallD=FlushE=1 for exactly 1 cycle once the E stage clears; StallE=0.
- Branch: BranchD=1, RsD=9, RFWEE=1, RtDE=9 -> brstall, StallD=1, FlushD=0 even with PCSrcD=1. Next cycle with no conflict and PCSrcD=1 -> FlushD=1.
- Memory wait, MEM_LAT=3: MemAccM pulse -> StallF/D/E/M=1, BubbleW=1 and MemBusy=0 in cycle 0; MemBusy=1 with stalls in cycle 1; MemBusy=1, stalls=0 in cycle 2; RUN in cycle 3. A second MemAccM in cycle 3 -> a new 2-cycle stall.
- Priority: memstall concurrent with lwstall -> FlushE=0 and StallE=1 during the wait; lwstall takes effect after the wait.
- Reset mid-wait: RST=1 in cycle 1 of a MEM_LAT=4 wait -> next cycle state RUN, MemBusy=0, all stalls 0. Also run MEM_LAT=1: MemAccM=1 never asserts stalls.
